// File: rtl/multi_cycle_mul_div.sv
// multi_cycle_mul_div: iterative RV32M multiply/divide unit, one bit per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise divides complete as illegal.
module multi_cycle_mul_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic [2:0]      dbg_state
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

`ifdef MULDIV_DIV_EN
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_FIX, S_DONE, S_DIV} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_FIX, S_DONE} state_t;
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   ma;
  logic [XLEN-1:0]   res_q;
  logic              neg;
  logic              skip;
  logic              ill_q;
  logic [2*XLEN-1:0] prod;

  // Handshake: start is taken only in IDLE (busy=0); done pulses one cycle with
  // result/illegal updated on that same edge, and result then holds until the next done.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] fix_val;

  assign a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) |
                    (funct3 == 3'b100) | (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  // Multiplier magnitude sits in the low half of prod and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} +
                    (prod[0] ? {1'b0, ma} : {(XLEN+1){1'b0}});
  assign prod_fix = neg ? -prod : prod;

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] mb, q, r;
  logic            neg_r;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] div_special, q_fix, r_fix;

  assign div_shift   = {r, q[XLEN-1]};
  assign div_diff    = {1'b0, div_shift} - {2'b00, mb};
  assign div_zero    = (b == '0);
  assign div_ovf     = ~funct3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign div_special = funct3[1] ? (div_zero ? a : '0) : (div_zero ? '1 : a);
  assign q_fix       = neg ? -q : q;
  assign r_fix       = neg_r ? -r : r;
`endif

  always_comb begin
    fix_val = '0;
    case (op)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      3'b100, 3'b101:         fix_val = q_fix;
      3'b110, 3'b111:         fix_val = r_fix;
`endif
      default:                fix_val = '0;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op      <= '0;
      ma      <= '0;
      res_q   <= '0;
      neg     <= 1'b0;
      skip    <= 1'b0;
      ill_q   <= 1'b0;
      prod    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      illegal <= 1'b0;
`ifdef MULDIV_DIV_EN
      mb      <= '0;
      q       <= '0;
      r       <= '0;
      neg_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op    <= funct3;
            ma    <= a_mag;
            neg   <= a_neg ^ b_neg;
            cnt   <= '0;
            prod  <= {{XLEN{1'b0}}, b_mag};
            busy  <= 1'b1;
            skip  <= 1'b0;
            ill_q <= 1'b0;
            if (!funct3[2]) begin
              state <= S_MUL;
            end else begin
`ifdef MULDIV_DIV_EN
              mb    <= b_mag;
              q     <= a_mag;
              r     <= '0;
              neg_r <= a_neg;
              if (div_zero || div_ovf) begin
                skip  <= 1'b1;
                res_q <= div_special;
                state <= S_FIX;
              end else begin
                state <= S_DIV;
              end
`else
              skip  <= 1'b1;
              ill_q <= 1'b1;
              res_q <= '0;
              state <= S_FIX;
`endif
            end
          end
        end
        S_MUL: begin
          prod <= {mul_sum, prod[XLEN-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          if (!div_diff[XLEN+1]) begin
            r <= div_diff[XLEN-1:0];
            q <= {q[XLEN-2:0], 1'b1};
          end else begin
            r <= div_shift[XLEN-1:0];
            q <= {q[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
`endif
        S_FIX: begin
          if (!skip) res_q <= fix_val;
          cnt   <= '0;
          state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          result  <= res_q;
          illegal <= ill_q;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_mul_div.sv
// tb_multi_cycle_mul_div: vector table, random ops and corner sequences with a
// done-driven scoreboard; follows MULDIV_DIV_EN to pick divide expectations.
module tb_multi_cycle_mul_div;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done, illegal;
  logic [31:0] result;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic        ill_q[$];
  logic [31:0] last_res = '0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x, y, er;
    int          lat;
    bit          ill;
    int          poke;
  } vec_t;
  vec_t vecs[$];

  multi_cycle_mul_div #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy, p;
    logic signed [31:0] t;
    logic ovf;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = ux * uy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * $signed(uy); return p[63:32]; end
      3'b011: begin p = ux * uy; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        t = $signed(x) / $signed(y);
        return t;
      end
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        t = $signed(x) % $signed(y);
        return t;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic add_vec(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input int poke);
    vec_t v;
    v.f = f; v.x = x; v.y = y; v.er = er; v.ill = 1'b0; v.poke = poke; v.lat = 34;
    if (f[2]) begin
`ifdef MULDIV_DIV_EN
      if (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) v.lat = 2;
`else
      v.er = '0; v.ill = 1'b1; v.lat = 2;
`endif
    end
    vecs.push_back(v);
  endtask

  // Drives one operation, pushes its expectation, and times done from the accepting edge.
  task automatic run_op(input vec_t v);
    int n;
    bit seen;
    @(negedge clk);
    funct3 = v.f; a = v.x; b = v.y; start = 1'b1;
    exp_q.push_back(v.er);
    ill_q.push_back(v.ill);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done) begin
        seen = 1;
      end else begin
        chk("busy_during_op", 32'(busy), 32'd1);
        chk("result_hold", result, last_res);
        if (v.poke == n) begin
          funct3 = ~v.f; a = ~v.x; b = v.y + 1; start = 1'b1;
        end
      end
    end
    start = 1'b0;
    if (!seen) begin
      errors++; checks++;
      $display("FAIL done_timeout: got no done after %0d edges, expected %0d", n, v.lat);
    end else begin
      chk("latency", 32'(n), 32'(v.lat));
    end
    last_res = v.er;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("result_after_done", result, v.er);
    if (v.poke > 0) repeat (40) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_done: got result %h, expected no done", result);
      end else begin
        chk("sb_result", result, exp_q.pop_front());
        chk("sb_illegal", 32'(illegal), 32'(ill_q.pop_front()));
      end
    end
  end

  initial begin
    vec_t v;
    logic [2:0] abort_f;
    reset = 1'b0; start = 1'b0; funct3 = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk) reset = 1'b1;

    add_vec(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);
    add_vec(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    add_vec(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    add_vec(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    add_vec(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    add_vec(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    add_vec(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    add_vec(3'b111, 32'd5,         32'd0,         32'd5,         0);
    add_vec(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    add_vec(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
    add_vec(3'b100, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, 0);
    add_vec(3'b110, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 0);
    add_vec(3'b101, 32'd100,       32'd7,         32'd14,        0);
    add_vec(3'b111, 32'd100,       32'd7,         32'd2,         0);
    add_vec(3'b100, 32'd8,         32'd2,         32'd4,         1);
    for (int i = 0; i < 20; i++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      add_vec(f, x, y, model(f, x, y), 0);
    end
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    v.f = 3'b000; v.x = 32'd7; v.y = 32'd9; v.er = 32'd63; v.ill = 0; v.lat = 34; v.poke = 0;
    run_op(v);
`ifdef MULDIV_DIV_EN
    abort_f = 3'b100;
`else
    abort_f = 3'b011;
`endif
    @(negedge clk);
    funct3 = abort_f; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    last_res = '0;
    repeat (5) @(posedge clk);
    v.f = 3'b000; v.x = 32'd3; v.y = 32'd4; v.er = 32'd12; v.ill = 0; v.lat = 34; v.poke = 0;
    run_op(v);

    repeat (50) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_cycle_mul_div.md
MULTI_CYCLE_MUL_DIV -- requirements
Module: multi_cycle_mul_div

Interface
REQ-001 SHALL have parameter XLEN, default 32, which sets the operand and result width (any even value >= 8).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port funct3, input, 3 bits, with RV32M encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports a and b, input, XLEN bits each: rs1 and rs2 operands, captured on the edge that accepts start.
REQ-007 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 SHALL have port result, output, XLEN bits: registered result, held until the next done.
REQ-010 SHALL have port illegal, output, 1 bit: valid with done; high when the operation was not supported.

Function
REQ-011 SHALL implement the FSM states IDLE, MUL, DIV, FIX and DONE.
REQ-012 SHALL, in IDLE with start=1, capture funct3, a and b on that edge and go to MUL (funct3[2]=0) or DIV (funct3[2]=1); special-case divides go directly to FIX.
REQ-013 SHALL ignore start while busy=1; no queueing.
REQ-014 SHALL in MUL run a shift-add over operand magnitudes, one bit per cycle, for exactly XLEN cycles, producing a 2*XLEN-bit product.
REQ-015 SHALL in DIV run restoring division over magnitudes, one quotient bit per cycle, for exactly XLEN cycles.
REQ-016 SHALL count iterations with a clog2(XLEN)+1-bit counter; leave MUL/DIV for FIX when the counter reaches XLEN-1.
REQ-017 SHALL in FIX apply sign correction and select the result, then go to DONE:
- MUL: low half
- MULH: signed x signed, high half
- MULHSU: signed a x unsigned b, high half
- MULHU: unsigned, high half
REQ-018 SHALL give DIV/REM a quotient truncated toward zero and a remainder taking the sign of the dividend.
REQ-019 SHALL treat b=0 as divide by zero: quotient all ones, remainder = a.
REQ-020 SHALL treat signed overflow (a = most negative, b = all ones, DIV/REM) as: quotient = a, remainder = 0.
REQ-021 SHALL in DONE assert done=1 for one cycle with result valid, then return to IDLE; start in DONE is ignored.
REQ-022 SHALL, for normal operations, assert done exactly XLEN+2 rising edges after the accepting edge; for special cases (REQ-019/020), exactly 2 edges after.
REQ-023 SHALL hold result stable from done until the next done; it does not change while busy.
REQ-024 SHALL hold illegal at 0 except as set by REQ-030.

Reset
REQ-025 SHALL on reset=0 immediately force, regardless of clk: state=IDLE, busy=0, done=0, illegal=0, result=0, counter=0, internal operands=0.
REQ-026 SHALL on reset mid-operation abort the operation with no done pulse; the first start after reset deasserts is accepted normally.

Configuration
REQ-027 SHALL use macro MULDIV_DIV_EN.
REQ-028 SHALL, when MULDIV_DIV_EN is defined, implement divide/remainder per REQ-015, 018, 019 and 020.
REQ-029 SHALL, when MULDIV_DIV_EN is undefined, compile out all divider datapath and the DIV state.
REQ-030 SHALL, when MULDIV_DIV_EN is undefined, complete funct3[2]=1 through FIX/DONE in 2 edges with result=0 and illegal=1; multiply behaviour is unchanged.

Verification (XLEN=32, MULDIV_DIV_EN defined unless noted)
REQ-031 SHALL cover MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 edges after accept, busy high throughout.
REQ-032 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000, and MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM of the same operands -> 0xFFFFFFFF, each at 34 edges.
REQ-034 SHALL cover the special cases, each with done at 2 edges:
- DIVU 5/0 -> 0xFFFFFFFF
- REMU 5/0 -> 5
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000
REQ-035 SHALL cover reset=0 asserted 10 cycles into a DIV: busy and result drop to 0 immediately with no done, and the next MUL 3 x 4 -> 12.
REQ-036 SHALL cover, with MULDIV_DIV_EN undefined, DIV 8/2: done at 2 edges, result 0, illegal 1; and start pulsed while busy is ignored.
